clock_hms_core: RTL and testbench
=================================

// Module: clock_hms_core
// PURPOSE
// - Single-clock timekeeping core: internal prescaler turns the system clock into a 1 Hz tick and drives sec/min/hour counters with carry.
// - Successor to the divided-clock 24h counter: no derived clocks; day length and input frequency are parameters; hour/minute set; blink dot.
// - Sits between board top (clk, buttons, switches) and the 7-segment controller; outputs are binary, one field per digit pair.
// PARAMETERS
// - CLK_HZ         50_000_000  input clock frequency; prescaler terminal count is CLK_HZ-1; must be even and >=2
// - HOURS_PER_DAY  24          hour counter modulus; legal range 2..32
// PORTS
// - clk        in   1  system clock; all state on rising edge
// - reset      in   1  asynchronous, active-high; clears all state
// - run        in   1  1 = time advances; 0 = prescaler and counters hold
// - set_h      in   1  level; while high, load hour from set_value (already synchronised/debounced)
// - set_m      in   1  level; while high, load minute from set_value, clear sec and prescaler
// - set_value  in   6  value loaded by set_h / set_m
// - sec        out  6  seconds 0..59
// - min        out  6  minutes 0..59
// - hour       out  5  hours 0..HOURS_PER_DAY-1
// - dot        out  1  high during first half of each second, low during second half
// - sec_tick   out  1  one-cycle pulse on each second increment
// - day_wrap   out  1  one-cycle pulse when 23:59:59 (HOURS_PER_DAY-1:59:59) wraps to 00:00:00
// BEHAVIOUR
// - Reset: prescaler=0, sec=0, min=0, hour=0, dot=1, sec_tick=0, day_wrap=0.
// - Prescaler: width $clog2(CLK_HZ); counts 0..CLK_HZ-1 when run=1, wraps to 0; holds when run=0.
// - Tick: internal tick true in cycle prescaler==CLK_HZ-1 && run; counters update on that edge; sec_tick registered, high exactly that following cycle.
// - dot: registered, 1 when prescaler < CLK_HZ/2 else 0; with run=0 dot freezes.
// - Carry chain on tick: sec 59->0 carries to min; min 59->0 carries to hour; hour HOURS_PER_DAY-1 -> 0 and day_wrap pulses one cycle (same cycle as sec_tick).
// - set_m=1 (any cycle, regardless of run): if set_value<=59 then min<=set_value, sec<=0, prescaler<=0; else min/sec/prescaler unchanged. No sec_tick, no carry into hour.
// - set_h=1: if set_value<HOURS_PER_DAY then hour<=set_value; else hour unchanged. No day_wrap.
// - Priority: set beats tick for the field being set; set_h+set_m both high -> both loads apply same cycle.
// - Tick coinciding with set_m: minute/sec take set values; hour does not receive carry from that tick.
// - Tick coinciding with set_h only: sec/min advance normally; hour takes set_value (carry discarded); day_wrap=0.
// - Reset mid-second or mid-set: immediate return to reset values; set inputs re-sampled on first edge after release.
// - Counters never hold out-of-range values; no arithmetic overflow beyond modulus.
// CONFIGURATION
// - ALARM_EN defined: adds ports alarm_set in 1, alarm_clr in 1, alarm out 1.
//   - alarm_set=1 captures alarm_h<=hour-format set_value when set_h, alarm_m<=set_value when set_m (same range checks), instead of loading time.
//   - alarm goes high on the edge where time becomes alarm_h:alarm_m:00 via tick (not via set); stays high until alarm_clr=1 or 60 s elapse.
//   - alarm reset value 0; alarm_h/alarm_m reset to 0; alarm_clr has priority over trigger in the same cycle.
// - ALARM_EN undefined: no alarm ports or registers; set_h/set_m always load time.
// TESTING (bench CLK_HZ=10, HOURS_PER_DAY=24 unless stated)
// - Reset release, run=1 for 10 cycles -> sec=1, sec_tick one cycle wide; dot high 5 cycles, low 5 cycles.
// - set_h=1 value 23, set_m=1 value 59, then 590 cycles run -> at 23:59:59 next tick gives 00:00:00 with day_wrap and sec_tick same cycle.
// - set_m with value 60, set_h with value 24 -> min/hour unchanged; value 59/23 accepted.
// - run=0 for 37 cycles mid-second -> sec, prescaler, dot frozen; resumes exact phase on run=1.
// - set_h=5 in the tick cycle of 00:59:59 -> result 05:00:00, day_wrap=0; HOURS_PER_DAY=12 run 11:59:59 -> 00:00:00.
// - ALARM_EN: alarm_set+set_h=0,set_m=1, time 00:00:50 -> alarm rises at 00:01:00, alarm_clr drops it; reset mid-count clears all.

Source files
------------

// File: rtl/clock_hms_if.sv
// Control inputs and time outputs of clock_hms_core, grouped as one bundle.
// The ALARM_EN build adds alarm_set, alarm_clr and alarm.
interface clock_hms_if;
  logic       run;
  logic       set_h;
  logic       set_m;
  logic [5:0] set_value;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       dot;
  logic       sec_tick;
  logic       day_wrap;
`ifdef ALARM_EN
  logic       alarm_set;
  logic       alarm_clr;
  logic       alarm;

  modport master (output run, set_h, set_m, set_value, alarm_set, alarm_clr,
                  input  sec, min, hour, dot, sec_tick, day_wrap, alarm);
  modport slave  (input  run, set_h, set_m, set_value, alarm_set, alarm_clr,
                  output sec, min, hour, dot, sec_tick, day_wrap, alarm);
`else
  modport master (output run, set_h, set_m, set_value,
                  input  sec, min, hour, dot, sec_tick, day_wrap);
  modport slave  (input  run, set_h, set_m, set_value,
                  output sec, min, hour, dot, sec_tick, day_wrap);
`endif
endinterface

// File: rtl/clock_hms_core.sv
// Single-clock h:m:s timekeeper with prescaler, hour/minute set and blink dot.
// Optional alarm comparator is enabled by defining ALARM_EN.
module clock_hms_core #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic        clk,
  input  logic        reset,
  clock_hms_if.slave  bus_io
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [4:0]    HOUR_MAX = 5'(HOURS_PER_DAY - 1);
  localparam logic [5:0]    HOUR_LIM = 6'(HOURS_PER_DAY);
  localparam logic [5:0]    MS_MAX   = 6'd59;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          dot_q, dot_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic tick_c, time_set_c, ld_m_c, ld_h_c, sec_carry_c, hr_carry_c;

`ifdef ALARM_EN
  logic [5:0] alarm_m_q, alarm_m_d;
  logic [4:0] alarm_h_q, alarm_h_d;
  logic [5:0] alarm_cnt_q, alarm_cnt_d;
  logic       alarm_q, alarm_d;
  logic       trig_c;
  assign time_set_c = ~bus_io.alarm_set;
`else
  assign time_set_c = 1'b1;
`endif

  // Next-state for prescaler, time fields and pulse outputs
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;

    tick_c      = bus_io.run && (presc_q == PRE_MAX);
    ld_m_c      = bus_io.set_m && (bus_io.set_value <= MS_MAX) && time_set_c;
    ld_h_c      = bus_io.set_h && (bus_io.set_value < HOUR_LIM) && time_set_c;
    sec_carry_c = tick_c && (sec_q == MS_MAX);
    // A minute load swallows the carry that would otherwise reach the hour
    hr_carry_c  = sec_carry_c && (min_q == MS_MAX) && !ld_m_c;

    if (ld_m_c) begin
      presc_d = '0;
    end else if (bus_io.run) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    if (ld_m_c) begin
      sec_d = '0;
      min_d = bus_io.set_value;
    end else if (tick_c) begin
      sec_d = sec_carry_c ? 6'd0 : sec_q + 6'd1;
      if (sec_carry_c) begin
        min_d = (min_q == MS_MAX) ? 6'd0 : min_q + 6'd1;
      end
    end

    if (ld_h_c) begin
      hour_d = 5'(bus_io.set_value);
    end else if (hr_carry_c) begin
      hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
    end

    tick_d = tick_c && !ld_m_c;
    wrap_d = hr_carry_c && (hour_q == HOUR_MAX) && !ld_h_c;
    dot_d  = presc_d < PRE_HALF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      dot_q   <= 1'b1;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      dot_q   <= dot_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef ALARM_EN
  // Alarm capture, trigger on a tick landing on hh:mm:00, 60 s auto-off
  always_comb begin
    alarm_m_d   = alarm_m_q;
    alarm_h_d   = alarm_h_q;
    alarm_cnt_d = alarm_cnt_q;
    alarm_d     = alarm_q;

    if (bus_io.alarm_set && bus_io.set_m && (bus_io.set_value <= MS_MAX)) begin
      alarm_m_d = bus_io.set_value;
    end
    if (bus_io.alarm_set && bus_io.set_h && (bus_io.set_value < HOUR_LIM)) begin
      alarm_h_d = 5'(bus_io.set_value);
    end

    trig_c = tick_c && !ld_m_c && !ld_h_c && (sec_d == 6'd0) &&
             (min_d == alarm_m_q) && (hour_d == alarm_h_q);

    if (bus_io.alarm_clr) begin
      alarm_d = 1'b0;
    end else if (trig_c) begin
      alarm_d     = 1'b1;
      alarm_cnt_d = '0;
    end else if (alarm_q && tick_c) begin
      if (alarm_cnt_q == MS_MAX) begin
        alarm_d = 1'b0;
      end else begin
        alarm_cnt_d = alarm_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_m_q   <= '0;
      alarm_h_q   <= '0;
      alarm_cnt_q <= '0;
      alarm_q     <= 1'b0;
    end else begin
      alarm_m_q   <= alarm_m_d;
      alarm_h_q   <= alarm_h_d;
      alarm_cnt_q <= alarm_cnt_d;
      alarm_q     <= alarm_d;
    end
  end

  assign bus_io.alarm = alarm_q;
`endif

  assign bus_io.sec      = sec_q;
  assign bus_io.min      = min_q;
  assign bus_io.hour     = hour_q;
  assign bus_io.dot      = dot_q;
  assign bus_io.sec_tick = tick_q;
  assign bus_io.day_wrap = wrap_q;

endmodule

// File: tb/tb_clock_hms_core.sv
// Bench for clock_hms_core: 24 h and 12 h instances driven in lockstep,
// checked every cycle against a seconds-of-day model plus literal expectations.
module tb_clock_hms_core;

  localparam int CLK = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_s, seth_s, setm_s, aset_s, aclr_s;
  logic [5:0] val_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_hms_if if24();
  clock_hms_if if12();

  assign if24.run = run_s;   assign if12.run = run_s;
  assign if24.set_h = seth_s; assign if12.set_h = seth_s;
  assign if24.set_m = setm_s; assign if12.set_m = setm_s;
  assign if24.set_value = val_s; assign if12.set_value = val_s;
`ifdef ALARM_EN
  assign if24.alarm_set = aset_s; assign if12.alarm_set = aset_s;
  assign if24.alarm_clr = aclr_s; assign if12.alarm_clr = aclr_s;
`endif

  clock_hms_core #(.CLK_HZ(CLK), .HOURS_PER_DAY(24)) dut24 (
    .clk(clk), .reset(reset), .bus_io(if24.slave));
  clock_hms_core #(.CLK_HZ(CLK), .HOURS_PER_DAY(12)) dut12 (
    .clk(clk), .reset(reset), .bus_io(if12.slave));

  // Model state: time as seconds since midnight, prescaler phase, last pulses
  int mt[2];
  int mp[2];
  bit mtk[2];
  bit mwr[2];
  int day_len[2] = '{86400, 43200};

  function automatic void model_step(input int t, input int p, input int day,
                                     input bit run, input bit sh, input bit sm,
                                     input int v, output int nt, output int np,
                                     output bit tk, output bit wr);
    bit tick, lm, lh;
    tick = run && (p == CLK - 1);
    lm   = sm && (v <= 59);
    lh   = sh && (v < day / 3600);
    np   = lm ? 0 : (run ? (p + 1) % CLK : p);
    if (lm) nt = (t / 3600) * 3600 + v * 60;
    else    nt = tick ? (t + 1) % day : t;
    if (lh) nt = v * 3600 + nt % 3600;
    tk = tick && !lm;
    wr = tick && (t == day - 1) && !lm && !lh;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int nt, np;
    bit tk, wr;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mt[i] <= 0; mp[i] <= 0; mtk[i] <= 1'b0; mwr[i] <= 1'b0;
      end else begin
        model_step(mt[i], mp[i], day_len[i], run_s, seth_s && !aset_s,
                   setm_s && !aset_s, int'(val_s), nt, np, tk, wr);
        mt[i] <= nt; mp[i] <= np; mtk[i] <= tk; mwr[i] <= wr;
      end
    end
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    check("m_sec24",  int'(if24.sec),      mt[0] % 60);
    check("m_min24",  int'(if24.min),      (mt[0] / 60) % 60);
    check("m_hour24", int'(if24.hour),     mt[0] / 3600);
    check("m_dot24",  int'(if24.dot),      int'(mp[0] < CLK / 2));
    check("m_tick24", int'(if24.sec_tick), int'(mtk[0]));
    check("m_wrap24", int'(if24.day_wrap), int'(mwr[0]));
    check("m_sec12",  int'(if12.sec),      mt[1] % 60);
    check("m_min12",  int'(if12.min),      (mt[1] / 60) % 60);
    check("m_hour12", int'(if12.hour),     mt[1] / 3600);
    check("m_dot12",  int'(if12.dot),      int'(mp[1] < CLK / 2));
    check("m_tick12", int'(if12.sec_tick), int'(mtk[1]));
    check("m_wrap12", int'(if12.day_wrap), int'(mwr[1]));
  end

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic sh, input logic sm, input int v);
    seth_s = sh;
    setm_s = sm;
    val_s  = 6'(v);
  endtask

  initial begin
    int hi;
    reset = 1'b1;
    run_s = 1'b0; aset_s = 1'b0; aclr_s = 1'b0;
    drive(1'b0, 1'b0, 0);
    step_n(2);
    reset = 1'b0;
    check("rst_sec",  int'(if24.sec), 0);
    check("rst_hour", int'(if24.hour), 0);
    check("rst_dot",  int'(if24.dot), 1);
    check("rst_tick", int'(if24.sec_tick), 0);

    // First second: dot 5 high / 5 low, then one-cycle sec_tick
    run_s = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(if24.dot);
      step_n(1);
    end
    check("dot_high_cycles", hi, 5);
    check("sec_after_10", int'(if24.sec), 1);
    check("tick_high", int'(if24.sec_tick), 1);
    step_n(1);
    check("tick_low", int'(if24.sec_tick), 0);

    // Freeze mid-second for 37 cycles, then resume on the same phase
    step_n(2);
    run_s = 1'b0;
    step_n(37);
    check("frz_sec", int'(if24.sec), 1);
    check("frz_dot", int'(if24.dot), 1);
    run_s = 1'b1;
    step_n(6);
    check("resume_pre_sec", int'(if24.sec), 1);
    check("resume_pre_dot", int'(if24.dot), 0);
    step_n(1);
    check("resume_sec", int'(if24.sec), 2);
    check("resume_tick", int'(if24.sec_tick), 1);

    // Out-of-range sets ignored, in-range accepted
    drive(1'b0, 1'b1, 60); step_n(1);
    check("bad_min", int'(if24.min), 0);
    drive(1'b1, 1'b0, 24); step_n(1);
    check("bad_hour", int'(if24.hour), 0);
    drive(1'b1, 1'b0, 23); step_n(1);
    check("set_h23", int'(if24.hour), 23);
    check("set_h23_12h", int'(if12.hour), 0);
    drive(1'b0, 1'b1, 59); step_n(1);
    check("set_m59", int'(if24.min), 59);
    check("set_m_sec", int'(if24.sec), 0);
    drive(1'b0, 1'b0, 0);

    // Day rollover on the 24 h instance
    step_n(590);
    check("pre_wrap_h", int'(if24.hour), 23);
    check("pre_wrap_s", int'(if24.sec), 59);
    step_n(10);
    check("wrap_hour", int'(if24.hour), 0);
    check("wrap_min",  int'(if24.min), 0);
    check("wrap_flag", int'(if24.day_wrap), 1);
    check("wrap_tick", int'(if24.sec_tick), 1);
    check("nowrap_12h_hour", int'(if12.hour), 1);

    // 11:59:59 wraps on the 12 h instance only
    drive(1'b1, 1'b0, 11); step_n(1);
    drive(1'b0, 1'b1, 59); step_n(1);
    drive(1'b0, 1'b0, 0);
    step_n(600);
    check("wrap12_hour", int'(if12.hour), 0);
    check("wrap12_flag", int'(if12.day_wrap), 1);
    check("h24_noon", int'(if24.hour), 12);
    check("h24_noon_wrap", int'(if24.day_wrap), 0);

    // set_h=5 on the tick that ends 00:59:59
    drive(1'b1, 1'b0, 0); step_n(1);
    drive(1'b0, 1'b1, 59); step_n(1);
    drive(1'b0, 1'b0, 0);
    step_n(599);
    check("pre_set_sec", int'(if24.sec), 59);
    drive(1'b1, 1'b0, 5); step_n(1);
    drive(1'b0, 1'b0, 0);
    check("seth_tick_hour", int'(if24.hour), 5);
    check("seth_tick_min",  int'(if24.min), 0);
    check("seth_tick_sec",  int'(if24.sec), 0);
    check("seth_tick_wrap", int'(if24.day_wrap), 0);
    check("seth_tick_stk",  int'(if24.sec_tick), 1);

    // Reset while a set is pending; set re-sampled after release
    step_n(3);
    drive(1'b0, 1'b1, 7);
    reset = 1'b1;
    #1;
    check("amid_rst_hour", int'(if24.hour), 0);
    check("amid_rst_dot",  int'(if24.dot), 1);
    step_n(2);
    reset = 1'b0;
    step_n(1);
    check("post_rst_min", int'(if24.min), 7);
    drive(1'b0, 1'b0, 0);

`ifdef ALARM_EN
    run_s = 1'b0;
    aset_s = 1'b1;
    drive(1'b0, 1'b1, 1); step_n(1);
    aset_s = 1'b0;
    check("alm_no_time_load", int'(if24.min), 7);
    drive(1'b0, 1'b1, 0); step_n(1);
    drive(1'b0, 1'b0, 0);
    run_s = 1'b1;
    step_n(599);
    check("alm_pre", int'(if24.alarm), 0);
    step_n(1);
    check("alm_rise", int'(if24.alarm), 1);
    check("alm_rise_min", int'(if24.min), 1);
    step_n(5);
    check("alm_hold", int'(if24.alarm), 1);
    aclr_s = 1'b1; step_n(1); aclr_s = 1'b0;
    check("alm_clr", int'(if24.alarm), 0);
    reset = 1'b1;
    #1;
    check("alm_rst", int'(if24.alarm), 0);
    step_n(1);
    reset = 1'b0;
`endif

    step_n(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
